tt_um_hoene_led_frame_deserializer: RTL and testbench
=====================================================

Name: tt_um_hoene_led_frame_deserializer

Overview:
Downstream stage of the Manchester decoder. Consumes its per-bit strobe (data, clk, error) and assembles MSB-first words of WORD_BITS bits. Counts word position within a frame and latches the word whose position equals this LED's address onto the colour output. Frame boundaries come from the decoder's error/unsynchronised flag.

Parameters:
WORD_BITS, 24, bits per word (one GRB colour triple)
IDX_W, 8, width of word index and address

Ports:
clk  in  1  global clock, all flops on rising edge
rst  in  1  asynchronous reset, active-high
bit_data  in  1  decoded bit value, qualified by bit_valid
bit_valid  in  1  one-cycle strobe per decoded bit (decoder out_clk)
bit_error  in  1  decoder unsynchronised/error level (decoder out_error)
addr  in  IDX_W  this LED's word position in the frame; sampled on each word completion
word_data  out  WORD_BITS  last completed word, held until next completion
word_valid  out  1  one-cycle pulse per completed word
word_index  out  IDX_W  position of word_data within the current frame, 0-based
color  out  WORD_BITS  latched colour for this LED
color_update  out  1  one-cycle pulse when color is reloaded
frame_end  out  1  one-cycle pulse: frame closed on a word boundary
frame_abort  out  1  one-cycle pulse: frame closed with a partial word pending
overflow  out  1  sticky: more than 2^IDX_W words in the current frame; cleared at next frame start

Behaviour:
- Reset (async, rst=1): state=UNSYNC; bit_cnt=0; word_cnt=0; shift=0. All outputs 0, including color (LED dark).
- FSM has two states.
- UNSYNC: ignore bit_valid. Leave when bit_error=0 is seen, going to RECV with bit_cnt=0, word_cnt=0, overflow cleared.
- RECV: each bit_valid with bit_error=0 does shift <= {shift[WORD_BITS-2:0], bit_data} and bit_cnt++.
- Word completion: when bit_valid arrives with bit_cnt==WORD_BITS-1, the next cycle shows:
  - word_valid=1
  - word_data = completed word
  - word_index = word_cnt
- On completion, bit_cnt wraps to 0 and word_cnt increments. Latency from final bit strobe to word_valid is exactly 1 cycle.
- Address match: at completion, if word_cnt==addr and overflow=0, color and color_update load in the same cycle as word_valid.
- Index saturation: word_cnt saturates at 2^IDX_W-1. The completion that would exceed that sets overflow. Later words still pulse word_valid with word_index=2^IDX_W-1 but never update color.
- RECV exit on bit_error=1:
  - bit_cnt==0: frame_end pulses next cycle.
  - bit_cnt!=0: frame_abort pulses next cycle and the partial word is discarded (word_data and color unchanged).
  - In both cases go to UNSYNC.
- bit_error has priority over bit_valid in the same cycle: the bit is dropped and the exit rule applies.
- Back-to-back bit_valid on consecutive cycles is legal. Completing words on consecutive cycles is legal only when WORD_BITS=1.
- Pulse outputs deassert the cycle after they assert. Only overflow, word_data, word_index and color hold.
- Reset asserted mid-frame clears everything immediately, including color. No end/abort pulse is emitted.

Decomposition:
- Package tt_um_hoene_led_pkg holds:
  - state enum {UNSYNC, RECV}
  - default WORD_BITS=24 and IDX_W=8 constants
- One sub-module, tt_um_hoene_bit_collector, holds the shift register, bit counter and completion strobe. Parameter: WORD_BITS. Inputs: clk, rst, clear, bit_data, bit_valid. Outputs: word, done.
- The top holds the FSM, word counter, address match and frame pulses.

Test Plan:
1. Reset, then bit_error=0, addr=0, 24 bits of 0xA5C3F0 MSB-first -> 1 cycle after 24th strobe: word_valid=1, word_data=0xA5C3F0, word_index=0, color_update=1, color=0xA5C3F0.
2. addr=2; words 0x111111, 0x222222, 0x333333, then bit_error=1 -> three word_valid pulses with index 0/1/2; color=0x333333 only after third; then frame_end=1, frame_abort=0.
3. addr=0; 10 bits then bit_error=1 -> frame_abort=1, no word_valid; color keeps its previous value; a new frame starts at word_index 0.
4. bit_valid and bit_error rising in the same cycle on bit 24 -> bit dropped, frame_abort=1, no word_valid.
5. IDX_W=2; 5 words, addr=3 -> indices 0,1,2,3,3; overflow=1 after 5th; color = 4th word only; overflow cleared after next bit_error 1->0.
6. rst pulsed mid-word (async, between clock edges) -> all outputs 0 immediately; following frame decodes word 0 correctly.

Source files
------------

// File: rtl/tt_um_hoene_led_pkg.sv
// Shared types and default sizes for the LED frame deserializer.
// The state enum is used by the top-level FSM.
// The constants give the default word and index widths, one GRB triple per word.
package tt_um_hoene_led_pkg;

  // Frame receiver state: waiting for the decoder to lock, or collecting words.
  typedef enum logic {
    UNSYNC = 1'b0,
    RECV   = 1'b1
  } state_t;

  localparam int DEF_WORD_BITS = 24;
  localparam int DEF_IDX_W     = 8;

endpackage

// File: rtl/tt_um_hoene_bit_collector.sv
// Shift register and bit counter that turn a stream of qualified bits into
// MSB-first words of WORD_BITS bits.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clear           drops any partial word and restarts the bit count
//   bit_data        bit value, taken when bit_valid is high
//   bit_valid       one-cycle strobe per accepted bit
//   word            word including the current bit_data (valid when done=1)
//   done            combinational: this strobe completes a word
module tt_um_hoene_bit_collector #(
  parameter int WORD_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 bit_data,
  input  logic                 bit_valid,
  output logic [WORD_BITS-1:0] word,
  output logic                 done
);

  localparam int CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic [CNT_W-1:0] bit_cnt;

  // done is left combinational so the top can register the word and raise
  // word_valid on the very next edge. That keeps the latency at one cycle.
  assign done = bit_valid && !clear && (bit_cnt == LAST_BIT);

  // Only the WORD_BITS-1 older bits need storage. The newest bit comes
  // straight from bit_data, so a completed word is available in the same
  // cycle as its final strobe.
  if (WORD_BITS > 1) begin : g_shift
    logic [WORD_BITS-2:0] hold_q;

    assign word = {hold_q, bit_data};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q <= '0;
      end else if (clear) begin
        hold_q <= '0;
      end else if (bit_valid) begin
        hold_q <= word[WORD_BITS-2:0];
      end
    end
  end else begin : g_single
    assign word = bit_data;
  end

  // Bit position within the current word. It wraps to 0 on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (bit_valid) begin
      bit_cnt <= done ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tt_um_hoene_led_frame_deserializer.sv
// Frame deserializer that follows the Manchester decoder. It assembles decoded
// bits into words and numbers the words within a frame. The word whose position
// matches this LED's address is latched as its colour. The decoder's error level
// marks frame boundaries.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   bit_data       decoded bit, qualified by bit_valid
//   bit_valid      one-cycle strobe per decoded bit
//   bit_error      decoder unsynchronised/error level
//   addr           this LED's word position, sampled on each word completion
//   word_data      last completed word (held)
//   word_valid     pulse per completed word
//   word_index     frame position of word_data (held, saturating)
//   color          latched colour for this LED (held)
//   color_update   pulse when color reloads
//   frame_end      pulse: frame closed on a word boundary
//   frame_abort    pulse: frame closed with a partial word discarded
//   overflow       sticky: more than 2^IDX_W words in this frame
module tt_um_hoene_led_frame_deserializer
  import tt_um_hoene_led_pkg::*;
#(
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_data,
  input  logic                 bit_valid,
  input  logic                 bit_error,
  input  logic [IDX_W-1:0]     addr,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  output logic [IDX_W-1:0]     word_index,
  output logic [WORD_BITS-1:0] color,
  output logic                 color_update,
  output logic                 frame_end,
  output logic                 frame_abort,
  output logic                 overflow
);

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_t               state;
  logic [IDX_W-1:0]     word_cnt;
  logic                 max_used;
  logic                 pending;
  logic                 accept;
  logic                 clear;
  logic                 done;
  logic                 over_now;
  logic                 addr_hit;
  logic [WORD_BITS-1:0] word;

  // bit_error takes priority over bit_valid. A bit that arrives together
  // with the error is dropped, and the collector is flushed instead.
  assign accept = (state == RECV) && bit_valid && !bit_error;
  assign clear  = (state == UNSYNC) || bit_error;

  tt_um_hoene_bit_collector #(
    .WORD_BITS(WORD_BITS)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bit_data (bit_data),
    .bit_valid(accept),
    .word     (word),
    .done     (done)
  );

  // word_cnt stops at IDX_MAX, so max_used records that the last index has
  // already been handed out. The completion after that one is the overflow
  // word. It must not reach the colour, even though overflow only becomes
  // visible on the same edge.
  assign over_now = (word_cnt == IDX_MAX) && max_used;
  assign addr_hit = (word_cnt == addr) && !overflow && !over_now;

  // Frame FSM. It also holds the word counter, the colour latch and all
  // registered outputs. Pulse outputs default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= UNSYNC;
      word_cnt     <= '0;
      max_used     <= 1'b0;
      pending      <= 1'b0;
      word_data    <= '0;
      word_valid   <= 1'b0;
      word_index   <= '0;
      color        <= '0;
      color_update <= 1'b0;
      frame_end    <= 1'b0;
      frame_abort  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      word_valid   <= 1'b0;
      color_update <= 1'b0;
      frame_end    <= 1'b0;
      frame_abort  <= 1'b0;
      case (state)
        UNSYNC: begin
          if (!bit_error) begin
            state    <= RECV;
            word_cnt <= '0;
            max_used <= 1'b0;
            pending  <= 1'b0;
            overflow <= 1'b0;
          end
        end
        RECV: begin
          if (bit_error) begin
            if (pending) begin
              frame_abort <= 1'b1;
            end else begin
              frame_end <= 1'b1;
            end
            pending <= 1'b0;
            state   <= UNSYNC;
          end else if (done) begin
            word_valid <= 1'b1;
            word_data  <= word;
            word_index <= word_cnt;
            pending    <= 1'b0;
            if (word_cnt == IDX_MAX) begin
              if (max_used) begin
                overflow <= 1'b1;
              end else begin
                max_used <= 1'b1;
              end
            end else begin
              word_cnt <= word_cnt + IDX_W'(1);
            end
            if (addr_hit) begin
              color        <= word;
              color_update <= 1'b1;
            end
          end else if (accept) begin
            pending <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_led_frame_deserializer.sv
// Self-checking bench for tt_um_hoene_led_frame_deserializer.
// A per-cycle behavioural model counts bits and words with plain integers, and
// every cycle is compared against it. Table vectors and hand-written sequences
// cover the frame corner cases. A second instance with IDX_W=2 exercises index
// saturation and overflow.
module tb_tt_um_hoene_led_frame_deserializer;

  localparam int WB = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_data;
  logic        bit_valid;
  logic        bit_error;
  logic [7:0]  addr;
  logic [1:0]  addr2;

  logic [23:0] word_data, color;
  logic        word_valid, color_update, frame_end, frame_abort, overflow;
  logic [7:0]  word_index;

  logic [23:0] word_data_2, color_2;
  logic        word_valid_2, color_update_2, frame_end_2, frame_abort_2, overflow_2;
  logic [1:0]  word_index_2;

  tt_um_hoene_led_frame_deserializer #(.WORD_BITS(24), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .bit_data(bit_data), .bit_valid(bit_valid),
    .bit_error(bit_error), .addr(addr), .word_data(word_data),
    .word_valid(word_valid), .word_index(word_index), .color(color),
    .color_update(color_update), .frame_end(frame_end),
    .frame_abort(frame_abort), .overflow(overflow)
  );

  tt_um_hoene_led_frame_deserializer #(.WORD_BITS(24), .IDX_W(2)) dut2 (
    .clk(clk), .rst(rst), .bit_data(bit_data), .bit_valid(bit_valid),
    .bit_error(bit_error), .addr(addr2), .word_data(word_data_2),
    .word_valid(word_valid_2), .word_index(word_index_2), .color(color_2),
    .color_update(color_update_2), .frame_end(frame_end_2),
    .frame_abort(frame_abort_2), .overflow(overflow_2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain counts of bits and words in the frame.
  bit          m_sync;
  int          m_bits;
  int          m_words;
  logic [23:0] m_acc;
  logic        e_wv, e_cu, e_fe, e_fa, e_ov;
  logic [23:0] e_wd, e_col;
  logic [7:0]  e_wi;

  typedef struct {
    logic        new_frame;
    logic [7:0]  addr;
    logic [23:0] word;
    logic [7:0]  exp_idx;
    logic        exp_cu;
    logic [23:0] exp_color;
  } vec_t;

  vec_t        tbl[4];
  logic [23:0] w5[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_bits = 0; m_words = 0; m_acc = '0;
    e_wv = 0; e_cu = 0; e_fe = 0; e_fa = 0; e_ov = 0;
    e_wd = '0; e_col = '0; e_wi = '0;
  endtask

  // Expected outputs after one clock edge with the given inputs.
  task automatic model_step(input logic v, input logic d, input logic e);
    e_wv = 0; e_cu = 0; e_fe = 0; e_fa = 0;
    if (!m_sync) begin
      if (!e) begin
        m_sync = 1; m_bits = 0; m_words = 0; e_ov = 0;
      end
    end else if (e) begin
      if (m_bits == 0) e_fe = 1; else e_fa = 1;
      m_sync = 0; m_bits = 0;
    end else if (v) begin
      m_acc = {m_acc[22:0], d};
      m_bits++;
      if (m_bits == WB) begin
        m_bits = 0;
        e_wv = 1;
        e_wd = m_acc;
        e_wi = (m_words > 255) ? 8'd255 : 8'(m_words);
        if (m_words > 255) e_ov = 1;
        else if (m_words == int'(addr)) begin
          e_col = m_acc; e_cu = 1;
        end
        m_words++;
      end
    end
  endtask

  task automatic checkOutput(input string name);
    check({name, "_word_valid"}, word_valid, e_wv);
    check({name, "_word_data"}, word_data, e_wd);
    check({name, "_word_index"}, word_index, e_wi);
    check({name, "_color"}, color, e_col);
    check({name, "_color_update"}, color_update, e_cu);
    check({name, "_frame_end"}, frame_end, e_fe);
    check({name, "_frame_abort"}, frame_abort, e_fa);
    check({name, "_overflow"}, overflow, e_ov);
  endtask

  // Inputs change on the falling edge. Outputs are read one full cycle later,
  // on the next falling edge, after the rising edge has consumed the inputs.
  task automatic applyStimulus(input logic v, input logic d, input logic e);
    bit_valid = v; bit_data = d; bit_error = e;
    model_step(v, d, e);
    @(negedge clk);
    checkOutput("cyc");
  endtask

  task automatic sendWord(input logic [23:0] w);
    for (int i = WB - 1; i >= 0; i--) applyStimulus(1'b1, w[i], 1'b0);
  endtask

  task automatic doReset();
    bit_valid = 0; bit_data = 0; bit_error = 1;
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checkOutput("reset");
  endtask

  initial begin
    rst = 1; bit_valid = 0; bit_data = 0; bit_error = 1; addr = 0; addr2 = 0;
    model_reset();

    tbl[0] = '{1'b0, 8'd0, 24'hA5C3F0, 8'd0, 1'b1, 24'hA5C3F0};
    tbl[1] = '{1'b1, 8'd2, 24'h111111, 8'd0, 1'b0, 24'hA5C3F0};
    tbl[2] = '{1'b0, 8'd2, 24'h222222, 8'd1, 1'b0, 24'hA5C3F0};
    tbl[3] = '{1'b0, 8'd2, 24'h333333, 8'd2, 1'b1, 24'h333333};

    // Reset state, then the table frames: a single word at address 0, then
    // three words with the match on the third.
    doReset();
    check("reset_color_2", color_2, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (tbl[k].new_frame) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        check("tbl_frame_end", frame_end, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
      end
      addr = tbl[k].addr;
      sendWord(tbl[k].word);
      check("tbl_word_valid", word_valid, 1'b1);
      check("tbl_word_data", word_data, tbl[k].word);
      check("tbl_word_index", word_index, tbl[k].exp_idx);
      check("tbl_color_update", color_update, tbl[k].exp_cu);
      check("tbl_color", color, tbl[k].exp_color);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("t2_frame_end", frame_end, 1'b1);
    check("t2_frame_abort", frame_abort, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("t2_end_deassert", frame_end, 1'b0);

    // Partial word aborted; the colour is kept and the next frame restarts at index 0.
    applyStimulus(1'b0, 1'b0, 1'b0);
    addr = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("t3_abort", frame_abort, 1'b1);
    check("t3_no_word", word_valid, 1'b0);
    check("t3_color_kept", color, 24'h333333);
    applyStimulus(1'b0, 1'b0, 1'b0);
    addr = 8'd5;
    sendWord(24'h0BCDEF);
    check("t3_new_index", word_index, 8'd0);
    check("t3_new_valid", word_valid, 1'b1);
    check("t3_color_still", color, 24'h333333);

    // An error arriving together with the final bit drops that bit.
    for (int i = 0; i < 23; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    check("t4_abort", frame_abort, 1'b1);
    check("t4_no_word", word_valid, 1'b0);

    // Index saturation and overflow on the IDX_W=2 instance.
    doReset();
    addr = 0; addr2 = 2'd3;
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) w5[k] = 24'($urandom) | 24'h1;
    for (int k = 0; k < 5; k++) begin
      sendWord(w5[k]);
      check("t5_valid2", word_valid_2, 1'b1);
      check("t5_index2", word_index_2, (k < 4) ? k : 3);
      check("t5_overflow2", overflow_2, (k == 4) ? 1'b1 : 1'b0);
      check("t5_update2", color_update_2, (k == 3) ? 1'b1 : 1'b0);
    end
    check("t5_color2", color_2, w5[3]);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("t5_end2", frame_end_2, 1'b1);
    check("t5_ov_sticky", overflow_2, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    check("t5_ov_cleared", overflow_2, 1'b0);

    // An asynchronous reset between edges clears everything, including color.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    bit_valid = 0; bit_error = 0;
    @(posedge clk);
    #2 rst = 1;
    #1;
    model_reset();
    checkOutput("t6_async");
    check("t6_color2", color_2, 24'h0);
    check("t6_index2", word_index_2, 2'd0);
    @(negedge clk);
    rst = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    addr = 0;
    sendWord(24'h5A5A5A);
    check("t6_word0", word_data, 24'h5A5A5A);
    check("t6_color", color, 24'h5A5A5A);
    check("t6_index", word_index, 8'd0);

    // Random traffic checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      addr = 8'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
